branch_resolve_queue: RTL and testbench

In-order tracking queue between the bimodal branch predictor/fetch stage and the execute stage. Records every predicted branch (PC, target, predicted direction) at fetch and pops the oldest entry when execute resolves the actual outcome. On a mismatch it raises a one-cycle flush with the correct redirect PC and drops all younger, wrong-path entries. It also emits a training update for the predictor's 2-bit state machine on every resolution, and keeps branch and mispredict statistics.

---
 rtl/branch_resolve_queue.sv | 118 +++++++++++
 tb/tb_branch_resolve_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   In-order queue of predicted branches between fetch and execute. Each
//   resolution pops the oldest entry and compares the actual direction with
//   the prediction. It emits a predictor training strobe on every pop. On a
//   mispredict it also emits a one-cycle flush with the corrected PC and drops
//   all queued wrong-path entries.
// Ports:
//   clk, reset (async, active-low)
//   pred_valid/pred_taken/pred_pc/pred_target, pred_ready : fetch side
//   res_valid/res_taken                                   : execute side
//   flush, redirect_pc                                    : mispredict redirect
//   upd_valid, upd_pc, upd_taken                          : predictor training
//   occupancy, branch_count, mispredict_count, res_error  : status
module branch_resolve_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [PC_W-1:0]          pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispredict_count,
  output logic                     res_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PC_W-1:0]  PC_ONE  = 1;

  logic [PC_W-1:0] mem_pc     [DEPTH];
  logic [PC_W-1:0] mem_target [DEPTH];
  logic            mem_taken  [DEPTH];

  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        enq, deq, mis;
  logic [PC_W-1:0] head_pc, head_target;
  logic            head_taken;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pred_ready = !full;
  assign occupancy  = wr_ptr - rd_ptr;

  assign head_pc     = mem_pc[rd_ptr[AW-1:0]];
  assign head_target = mem_target[rd_ptr[AW-1:0]];
  assign head_taken  = mem_taken[rd_ptr[AW-1:0]];

  // Fetch during the flush cycle is wrong-path and is dropped.
  assign enq = pred_valid && !full && !flush;
  assign deq = res_valid && !empty;
  assign mis = deq && (res_taken != head_taken);

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr[AW-1:0]]     <= pred_pc;
      mem_target[wr_ptr[AW-1:0]] <= pred_target;
      mem_taken[wr_ptr[AW-1:0]]  <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
      upd_valid        <= 1'b0;
      upd_pc           <= '0;
      upd_taken        <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
      res_error        <= 1'b0;
    end else begin
      flush     <= mis;
      upd_valid <= deq;

      if (mis) begin
        // Clear by snapping the read pointer onto the un-advanced write
        // pointer, so a same-cycle enqueue is discarded too.
        rd_ptr <= wr_ptr;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      end

      if (deq) begin
        upd_pc    <= head_pc;
        upd_taken <= res_taken;
        if (branch_count != '1) branch_count <= branch_count + CNT_ONE;
      end

      if (mis) begin
        redirect_pc <= res_taken ? head_target : head_pc + PC_ONE;
        if (mispredict_count != '1) mispredict_count <= mispredict_count + CNT_ONE;
      end

      if (res_valid && empty) res_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            pred_valid, pred_taken;
  logic [PC_W-1:0] pred_pc, pred_target;
  logic            pred_ready;
  logic            res_valid, res_taken;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [2:0]      occupancy;
  logic [CNT_W-1:0] branch_count, mispredict_count;
  logic            res_error;

  branch_resolve_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .occupancy(occupancy), .branch_count(branch_count),
    .mispredict_count(mispredict_count), .res_error(res_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [31:0] pc,
                       input logic [31:0] tg, input logic rv, input logic rt);
    pred_valid = pv; pred_taken = pt; pred_pc = pc; pred_target = tg;
    res_valid = rv; res_taken = rt;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_occ"},   32'(occupancy), 0);
    check({tag, "_ready"}, 32'(pred_ready), 1);
    check({tag, "_flush"}, 32'(flush), 0);
    check({tag, "_redir"}, redirect_pc, 0);
    check({tag, "_updv"},  32'(upd_valid), 0);
    check({tag, "_updpc"}, upd_pc, 0);
    check({tag, "_updt"},  32'(upd_taken), 0);
    check({tag, "_bc"},    32'(branch_count), 0);
    check({tag, "_mc"},    32'(mispredict_count), 0);
    check({tag, "_err"},   32'(res_error), 0);
  endtask

  typedef struct {
    logic        pv, pt;
    logic [31:0] pc, tg;
    logic        rv, rt;
    int          occ;
    logic        rdy, fl;
    logic [31:0] redir;
    logic        uv;
    logic [31:0] upc;
    int          bc, mc;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pv, logic pt, logic [31:0] pc, logic [31:0] tg,
                              logic rv, logic rt, int occ, logic fl, logic [31:0] redir,
                              logic uv, logic [31:0] upc, int bc, int mc, logic err);
    vec_t v;
    v.pv = pv; v.pt = pt; v.pc = pc; v.tg = tg; v.rv = rv; v.rt = rt;
    v.occ = occ; v.rdy = (occ < DEPTH); v.fl = fl; v.redir = redir;
    v.uv = uv; v.upc = upc; v.bc = bc; v.mc = mc; v.err = err;
    return v;
  endfunction

  // Reference model state
  typedef struct { logic [31:0] pc, tg; logic tk; } ent_t;
  ent_t        mq[$];
  logic        m_flush, m_upd, m_updt, m_err;
  logic [31:0] m_redir, m_updpc;
  int          m_bc, m_mc;

  task automatic model_reset();
    mq.delete();
    m_flush = 0; m_upd = 0; m_updt = 0; m_err = 0;
    m_redir = 0; m_updpc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic model_step(input logic pv, input logic pt, input logic [31:0] pc,
                            input logic [31:0] tg, input logic rv, input logic rt);
    ent_t e;
    bit   accept;
    accept = pv && (mq.size() < DEPTH) && !m_flush;
    m_flush = 0;
    m_upd = 0;
    if (rv) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_upd = 1; m_updpc = e.pc; m_updt = rt;
        if (m_bc < 15) m_bc++;
        if (rt != e.tk) begin
          m_flush = 1;
          m_redir = rt ? e.tg : e.pc + 32'd1;
          if (m_mc < 15) m_mc++;
          mq.delete();
          accept = 0;
        end
      end else begin
        m_err = 1;
      end
    end
    if (accept) begin
      e.pc = pc; e.tg = tg; e.tk = pt;
      mq.push_back(e);
    end
  endtask

  initial begin
    // Directed table: the test-plan scenarios in order.
    vecs.push_back(mk(1,1,32'h10,32'h40, 0,0, 1,0,0, 0,0,    0,0,0));
    vecs.push_back(mk(0,0,0,0,           1,1, 0,0,0, 1,32'h10,1,0,0));
    vecs.push_back(mk(1,0,32'h20,32'h80, 0,0, 1,0,0, 0,0,    1,0,0));
    vecs.push_back(mk(1,0,32'h24,32'h100,0,0, 2,0,0, 0,0,    1,0,0));
    vecs.push_back(mk(1,0,32'h28,32'h104,0,0, 3,0,0, 0,0,    1,0,0));
    vecs.push_back(mk(1,0,32'h2c,32'h108,1,1, 0,1,32'h80, 1,32'h20,2,1,0));
    vecs.push_back(mk(1,1,32'h30,32'h90, 0,0, 0,0,0, 0,0,    2,1,0));
    vecs.push_back(mk(1,1,32'h30,32'h90, 0,0, 1,0,0, 0,0,    2,1,0));
    vecs.push_back(mk(0,0,0,0,           1,0, 0,1,32'h31, 1,32'h30,3,2,0));
    vecs.push_back(mk(1,0,32'h44,32'h0,  0,0, 0,0,0, 0,0,    3,2,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,32'h50+i,32'h0,0,0, (i < 4) ? i+1 : 4,0,0, 0,0,3,2,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,0,1,0, 3-i,0,0, 1,32'h50+i,4+i,2,0));
    vecs.push_back(mk(0,0,0,0,           1,0, 0,0,0, 0,0,    7,2,1));
    vecs.push_back(mk(1,1,32'h60,32'h70, 0,0, 1,0,0, 0,0,    7,2,1));
    vecs.push_back(mk(1,1,32'h61,32'h71, 1,1, 1,0,0, 1,32'h60,8,2,1));
    vecs.push_back(mk(0,0,0,0,           1,1, 0,0,0, 1,32'h61,9,2,1));

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check_reset_values("reset");
    cycle();
    reset = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      string t;
      v = vecs[i];
      drive(v.pv, v.pt, v.pc, v.tg, v.rv, v.rt);
      cycle();
      t = $sformatf("vec%0d", i);
      check({t, "_occ"},   32'(occupancy), 32'(v.occ));
      check({t, "_ready"}, 32'(pred_ready), 32'(v.rdy));
      check({t, "_flush"}, 32'(flush), 32'(v.fl));
      if (v.fl) check({t, "_redir"}, redirect_pc, v.redir);
      check({t, "_updv"},  32'(upd_valid), 32'(v.uv));
      if (v.uv) check({t, "_updpc"}, upd_pc, v.upc);
      check({t, "_bc"},    32'(branch_count), 32'(v.bc));
      check({t, "_mc"},    32'(mispredict_count), 32'(v.mc));
      check({t, "_err"},   32'(res_error), 32'(v.err));
    end

    // Asynchronous reset with three entries queued and res_error set.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h200 + i, 32'h300, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("async_pre_occ", 32'(occupancy), 3);
    #2 reset = 1'b0;
    #1;
    check_reset_values("async");
    cycle();
    reset = 1'b1;

    // Counter saturation: 20 matching resolves on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 32'h400 + i, 32'h500, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 1, 1);
      cycle();
      check("sat_updpc", upd_pc, 32'h400 + i);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("sat_bc", 32'(branch_count), 15);
    check("sat_mc", 32'(mispredict_count), 0);

    // Randomized run against the queue-level reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic pv, pt, rv, rt;
      logic [31:0] pc, tg;
      pv = ($urandom_range(0, 99) < 60);
      pt = $urandom_range(0, 1);
      pc = $urandom;
      tg = $urandom;
      rv = ($urandom_range(0, 99) < 40);
      rt = ($urandom_range(0, 99) < 75) ? pt : ~pt;
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) rt = mq[0].tk ^ ($urandom_range(0, 4) == 0);
      drive(pv, pt, pc, tg, rv, rt);
      model_step(pv, pt, pc, tg, rv, rt);
      cycle();
      check("rnd_occ",   32'(occupancy), 32'(mq.size()));
      check("rnd_ready", 32'(pred_ready), 32'(mq.size() < DEPTH));
      check("rnd_flush", 32'(flush), 32'(m_flush));
      if (m_flush) check("rnd_redir", redirect_pc, m_redir);
      check("rnd_updv",  32'(upd_valid), 32'(m_upd));
      if (m_upd) begin
        check("rnd_updpc", upd_pc, m_updpc);
        check("rnd_updt",  32'(upd_taken), 32'(m_updt));
      end
      check("rnd_bc",  32'(branch_count), 32'(m_bc));
      check("rnd_mc",  32'(mispredict_count), 32'(m_mc));
      check("rnd_err", 32'(res_error), 32'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
